u_rca16_rr_arbiter: RTL
=======================

// Module: u_rca16_rr_arbiter
// PURPOSE
//   Shares one 16-bit unsigned ripple-carry adder between NREQ requesters.
//   Each requester presents an (a, b) operand pair over a valid/ready handshake.
//   A round-robin arbiter picks one request per cycle and adds it in the shared adder.
//   The {carry, sum} result goes into a one-entry output register, tagged with the winning requester ID.
//   The block sits between the operand-producing engines and the pg-style adder datapath.
// PARAMETERS
//   NREQ   4              number of requesters (2..16)
//   WIDTH  16             operand width; the result is WIDTH+1 bits
//   IDW    $clog2(NREQ)   width of the requester ID
// PORTS
//   clk        in   1            single clock; all state updates on the rising edge
//   rst        in   1            synchronous, active-high reset
//   req_valid  in   NREQ         bit i: requester i presents an operand pair
//   req_a      in   NREQ*WIDTH   operand a of requester i in bits [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH   operand b of requester i in bits [i*WIDTH +: WIDTH]
//   req_ready  out  NREQ         one-hot or zero; bit i high = requester i accepted this cycle
//   res_valid  out  1            output register holds a result
//   res_ready  in   1            consumer accepts the result
//   res_sum    out  WIDTH+1      {carry_out, sum} = a + b, unsigned
//   res_id     out  IDW          index of the requester that produced res_sum
// BEHAVIOUR
//   Output register states:
//   - EMPTY (res_valid=0), FULL (res_valid=1).
//   - accept_en = !res_valid | res_ready.
//   Arbitration (combinational):
//   - Search order starts at ptr+1 mod NREQ and wraps; the first i with req_valid[i] wins.
//   - req_ready[i] = (i == winner) & accept_en & |req_valid.
//   - req_ready may depend on req_valid. Requesters must never make req_valid depend on req_ready.
//   Transfer on a rising edge where req_valid[i] & req_ready[i]:
//   - res_sum  <= req_a[i] + req_b[i], zero-extended to WIDTH+1. Carry-out is the MSB; no wrap or truncation.
//   - res_id   <= i
//   - res_valid<= 1
//   - ptr      <= i
//   Latency: exactly 1 cycle from the accepting edge to res_valid/res_sum visible.
//   Consume: if res_valid & res_ready and there is no new transfer, res_valid <= 0.
//   Simultaneous consume and transfer in one cycle:
//   - The register is reloaded with the new result; res_valid stays 1.
//   - Full throughput is one result per cycle.
//   FULL & !res_ready:
//   - req_ready is all 0.
//   - res_sum, res_id and res_valid hold stable.
//   - ptr does not move.
//   No valid requests: ptr holds and req_ready is all 0.
//   Fairness:
//   - Once req_valid[i] is high, requester i wins within at most NREQ-1 transfers to other requesters.
//   Requester protocol:
//   - Keep req_valid and operands stable until accepted.
//   - A request dropped before acceptance is ignored; no error is raised.
//   Reset (rst=1 at an edge):
//   - res_valid=0, res_sum=0, res_id=0, ptr=NREQ-1, so requester 0 has top priority after reset.
//   - req_ready is all 0 while rst=1.
//   - A result held in the register when reset is asserted is discarded, not delivered.
// TESTING
//   T1 single:
//      rst, then req_valid=0001, a0=16'h1234, b0=16'h0FED.
//      -> req_ready=0001 in that cycle; next cycle res_valid=1, res_sum=17'h02221, res_id=0.
//   T2 carry:
//      a2=16'hFFFF, b2=16'h0001, res_ready=1.
//      -> res_sum=17'h10000, res_id=2; 16'hFFFF+16'hFFFF -> 17'h1FFFE.
//   T3 round-robin:
//      all 4 req_valid held high, res_ready=1.
//      -> winners 0,1,2,3,0,1 on consecutive cycles; res_valid stays high every cycle.
//   T4 backpressure:
//      FULL with res_ready=0 for 5 cycles, req_valid=1111.
//      -> req_ready=0000, res_sum and res_id frozen, ptr unchanged.
//      -> after res_ready=1, the next winner is ptr+1.
//   T5 sparse:
//      ptr=1, req_valid=1001.
//      -> winner 3, then winner 0; requester 1 idle, so it is skipped.
//   T6 reset mid-op:
//      FULL with res_sum=17'h0ABCD, assert rst for 1 cycle.
//      -> res_valid=0, res_sum=0, res_id=0; the next request from req_valid=1111 goes to requester 0.

Source files
------------

// File: rtl/u_rca16_rr_arbiter_if.sv
// Handshake bundle between the operand-producing requesters, the shared-adder
// arbiter and the result consumer.
interface u_rca16_rr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH:0]        res_sum;
    logic [IDW-1:0]        res_id;

    // Requesters and consumer side.
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_id
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_id
    );
endinterface

// File: rtl/u_rca16_rr_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder between NREQ requesters,
// with a one-entry result register tagged by the winning requester ID.
module u_rca16_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = $clog2(NREQ)
) (
    input logic                 clk,
    input logic                 rst,
    u_rca16_rr_arbiter_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic             any_req;
    logic             accept_en;
    logic             xfer;
    logic [NREQ-1:0]  req_ready;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   carry;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   res_sum_q;
    logic [IDW-1:0]   res_id_q;

    // Scan from the farthest candidate to the nearest so the last hit is ptr+1 onwards.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        winner  = ptr;
        any_req = |bus.req_valid;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req_valid[(int'(ptr) + k) % NREQ])
                winner = IDW'((int'(ptr) + k) % NREQ);
        end
    end

    assign accept_en = (state == EMPTY) | bus.res_ready;
    assign xfer      = !rst & any_req & accept_en;

    always_comb begin
        req_ready = '0;
        if (xfer)
            req_ready[winner] = 1'b1;
    end

    assign op_a = bus.req_a[winner*WIDTH +: WIDTH];
    assign op_b = bus.req_b[winner*WIDTH +: WIDTH];

    // Shared ripple-carry adder: generate/propagate per bit, carry rippling upward.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = op_a[i] ^ op_b[i] ^ carry[i];
            carry[i+1] = (op_a[i] & op_b[i]) | ((op_a[i] ^ op_b[i]) & carry[i]);
        end
        sum[WIDTH] = carry[WIDTH];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (xfer) state_nxt = FULL;
            FULL:  if (bus.res_ready && !xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state     <= EMPTY;
            res_sum_q <= '0;
            res_id_q  <= '0;
            ptr       <= IDW'(NREQ - 1);
        end else begin
            state <= state_nxt;
            if (xfer) begin
                res_sum_q <= sum;
                res_id_q  <= winner;
                ptr       <= winner;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.res_valid = (state == FULL);
    assign bus.res_sum   = res_sum_q;
    assign bus.res_id    = res_id_q;
endmodule
